// File: rtl/n3l_pkg.sv
// Shared types and constants for the half-shell cell-pair scheduler.
// Holds the Newton's-3rd-law neighbor offset table and the FSM state encoding.
package n3l_pkg;

   localparam int HALF_SHELL_N = 13;
   localparam int K_W          = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef struct packed {
      logic signed [1:0] dx;
      logic signed [1:0] dy;
      logic signed [1:0] dz;
   } shell_off_t;

   // Entry i holds offset k=i+1; 01=+1, 00=0, 11=-1; first nonzero component is always +1.
   localparam shell_off_t HALF_SHELL [HALF_SHELL_N] = '{
      6'b01_11_11,
      6'b01_00_11,
      6'b01_01_11,
      6'b01_11_00,
      6'b01_00_00,
      6'b01_01_00,
      6'b01_11_01,
      6'b01_00_01,
      6'b01_01_01,
      6'b00_01_11,
      6'b00_01_00,
      6'b00_01_01,
      6'b00_00_01
   };

   function automatic shell_off_t shell_offset(input logic [K_W-1:0] k);
      shell_off_t off;
      off = '0;
      if ((k != '0) && (k <= K_W'(HALF_SHELL_N))) begin
         off = HALF_SHELL[k - K_W'(1)];
      end
      return off;
   endfunction

endpackage

// File: rtl/n3l_wrap_step.sv
// Periodic single-step coordinate update: c + d with d in {-1,0,+1}, wrapping inside [0, N-1].
// Uses compares instead of a modulo so no divider is inferred.
module n3l_wrap_step #(
   parameter int N = 3,
   parameter int W = 32
) (
   input  logic [W-1:0]      c_i,
   input  logic signed [1:0] d_i,
   output logic [W-1:0]      c_o
);

   localparam logic [W-1:0] MAX_C = W'(N - 1);

   always_comb begin
      c_o = c_i;
      if (d_i == 2'sb01) begin
         c_o = (c_i == MAX_C) ? '0 : c_i + W'(1);
      end else if (d_i == 2'sb11) begin
         c_o = (c_i == '0) ? MAX_C : c_i - W'(1);
      end
   end

endmodule

// File: rtl/n3l_pair_scheduler.sv
// Walks every reference cell of the periodic N^3 universe and streams (ref, nbr) half-shell pairs.
// All pair outputs are registered; the next pair is precomputed from next-state counters.
module n3l_pair_scheduler
   import n3l_pkg::*;
#(
   parameter int UNIVERSE_SIZE = 3,
   parameter int CELL_W        = 32,
   parameter bit INCLUDE_HOME  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pair_valid,
   input  logic              pair_ready,
   output logic [CELL_W-1:0] pair_ref_cell,
   output logic [CELL_W-1:0] pair_nbr_cell,
   output logic              pair_home,
   output logic              pair_last
);

   localparam logic [CELL_W-1:0] N_C     = CELL_W'(UNIVERSE_SIZE);
   localparam logic [CELL_W-1:0] NN_C    = CELL_W'(UNIVERSE_SIZE * UNIVERSE_SIZE);
   localparam logic [CELL_W-1:0] MAX_C   = CELL_W'(UNIVERSE_SIZE - 1);
   localparam logic [CELL_W-1:0] ONE_C   = CELL_W'(1);
   localparam logic [K_W-1:0]    K_FIRST = K_W'(INCLUDE_HOME ? 0 : 1);
   localparam logic [K_W-1:0]    K_LAST  = K_W'(HALF_SHELL_N);

   state_t            state_q, state_d;
   logic [CELL_W-1:0] x_q, x_d;
   logic [CELL_W-1:0] y_q, y_d;
   logic [CELL_W-1:0] z_q, z_d;
   logic [K_W-1:0]    k_q, k_d;

   logic              valid_q, done_q, home_q, last_q;
   logic [CELL_W-1:0] ref_q, nbr_q;

   logic              hs;
   shell_off_t        off_d;
   logic [CELL_W-1:0] nx, ny, nz;
   logic [CELL_W-1:0] ref_d, nbr_d;
   logic              home_d, last_d;

   assign hs = valid_q & pair_ready;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               x_d     = '0;
               y_d     = '0;
               z_d     = '0;
               k_d     = K_FIRST;
            end
         end
         RUN: begin
            if (hs) begin
               if (last_q) begin
                  state_d = DONE;
               end else if (k_q == K_LAST) begin
                  // Offset list exhausted: move to the next reference cell, x fastest.
                  k_d = K_FIRST;
                  if (x_q == MAX_C) begin
                     x_d = '0;
                     if (y_q == MAX_C) begin
                        y_d = '0;
                        z_d = z_q + ONE_C;
                     end else begin
                        y_d = y_q + ONE_C;
                     end
                  end else begin
                     x_d = x_q + ONE_C;
                  end
               end else begin
                  k_d = k_q + K_W'(1);
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign off_d = shell_offset(k_d);

   n3l_wrap_step #(.N(UNIVERSE_SIZE), .W(CELL_W)) u_wrap_x (
      .c_i (x_d),
      .d_i (off_d.dx),
      .c_o (nx)
   );

   n3l_wrap_step #(.N(UNIVERSE_SIZE), .W(CELL_W)) u_wrap_y (
      .c_i (y_d),
      .d_i (off_d.dy),
      .c_o (ny)
   );

   n3l_wrap_step #(.N(UNIVERSE_SIZE), .W(CELL_W)) u_wrap_z (
      .c_i (z_d),
      .d_i (off_d.dz),
      .c_o (nz)
   );

   assign ref_d  = x_d + N_C * y_d + NN_C * z_d;
   assign nbr_d  = nx + N_C * ny + NN_C * nz;
   assign home_d = (k_d == '0);
   assign last_d = (x_d == MAX_C) && (y_d == MAX_C) && (z_d == MAX_C) && (k_d == K_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         k_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         home_q  <= 1'b0;
         last_q  <= 1'b0;
         ref_q   <= '0;
         nbr_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         k_q     <= k_d;
         valid_q <= (state_d == RUN);
         done_q  <= (state_d == DONE);
         // Stalled cycles recompute the same pair from unchanged counters, so fields hold.
         if (state_d == RUN) begin
            ref_q  <= ref_d;
            nbr_q  <= nbr_d;
            home_q <= home_d;
            last_q <= last_d;
         end else begin
            ref_q  <= '0;
            nbr_q  <= '0;
            home_q <= 1'b0;
            last_q <= 1'b0;
         end
      end
   end

   assign busy          = valid_q;
   assign done          = done_q;
   assign pair_valid    = valid_q;
   assign pair_ref_cell = ref_q;
   assign pair_nbr_cell = nbr_q;
   assign pair_home     = home_q;
   assign pair_last     = last_q;

endmodule

// File: tb/tb_n3l_pair_scheduler.sv
// Directed bench for n3l_pair_scheduler: N=3 with home pairs, and N=4 without home pairs.
// Expected pairs come from an index-based modular model and hand-computed constants.
module tb_n3l_pair_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start3, ready3, start4, ready4;
   logic        busy3, done3, valid3, home3, last3;
   logic        busy4, done4, valid4, home4, last4;
   logic [31:0] ref3, nbr3, ref4, nbr4;

   int n_checks = 0;
   int n_fail   = 0;

   int DX[14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
   int DY[14] = '{0,-1, 0, 1,-1, 0, 1,-1, 0, 1, 1, 1, 1, 0};
   int DZ[14] = '{0,-1,-1,-1, 0, 0, 0, 1, 1, 1,-1, 0, 1, 1};

   int          idx, cyc, rose, homes, pairs_ok, bad;
   int          sb[27][27];
   logic [65:0] p1, p13, plast, held;

   n3l_pair_scheduler #(.UNIVERSE_SIZE(3), .CELL_W(32), .INCLUDE_HOME(1'b1)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
      .pair_valid(valid3), .pair_ready(ready3), .pair_ref_cell(ref3),
      .pair_nbr_cell(nbr3), .pair_home(home3), .pair_last(last3)
   );

   n3l_pair_scheduler #(.UNIVERSE_SIZE(4), .CELL_W(32), .INCLUDE_HOME(1'b0)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
      .pair_valid(valid4), .pair_ready(ready4), .pair_ref_cell(ref4),
      .pair_nbr_cell(nbr4), .pair_home(home4), .pair_last(last4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [65:0] pk3();
      return {home3, last3, ref3, nbr3};
   endfunction

   function automatic logic [65:0] pk4();
      return {home4, last4, ref4, nbr4};
   endfunction

   // Pair i of a sweep: {home, last, ref, nbr}, neighbor wrapped with plain modulo.
   function automatic logic [65:0] model(input int n, input int inc, input int i);
      int per, k, r, x, y, z, nx, ny, nz, nbr;
      per = 13 + inc;
      k   = (i % per) + ((inc != 0) ? 0 : 1);
      r   = i / per;
      x   = r % n;
      y   = (r / n) % n;
      z   = r / (n * n);
      nx  = (x + DX[k] + n) % n;
      ny  = (y + DY[k] + n) % n;
      nz  = (z + DZ[k] + n) % n;
      nbr = nx + n * ny + n * n * nz;
      return {(k == 0), ((r == n * n * n - 1) && (k == 13)), 32'(r), 32'(nbr)};
   endfunction

   initial begin
      // 1. reset and idle
      rst = 1'b1; start3 = 1'b0; ready3 = 1'b0; start4 = 1'b0; ready4 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk_bit("rst_valid", valid3, 1'b0);
      chk_bit("rst_busy", busy3, 1'b0);
      chk_bit("rst_done", done3, 1'b0);
      chk("rst_pair", pk3(), 66'd0);
      chk_bit("rst_valid4", valid4, 1'b0);
      rose = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (valid3 || busy3 || done3 || valid4) rose = 1;
      end
      chk_int("idle_no_valid", rose, 0);

      // 2. full sweep with ready held high
      ready3 = 1'b1; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      chk_bit("t2_busy_first", busy3, 1'b1);
      chk("t2_pair0", pk3(), {1'b1, 1'b0, 32'd0, 32'd0});
      idx = 0; cyc = 0; p1 = '0; p13 = '0; plast = '0;
      while (idx < 378 && cyc < 1000) begin
         if (valid3 && ready3) begin
            chk($sformatf("t2_pair%0d", idx), pk3(), model(3, 1, idx));
            if (idx == 1) p1 = pk3();
            if (idx == 13) p13 = pk3();
            if (idx == 377) plast = pk3();
            idx++;
         end
         tick();
         cyc++;
      end
      chk_int("t2_pair_count", idx, 378);
      chk_int("t2_cycles", cyc, 378);
      chk("t2_pair1", p1, {1'b0, 1'b0, 32'd0, 32'd25});
      chk("t2_pair13", p13, {1'b0, 1'b0, 32'd0, 32'd9});
      chk("t2_pair_last", plast, {1'b0, 1'b1, 32'd26, 32'd8});
      chk_bit("t2_done", done3, 1'b1);
      chk_bit("t2_valid_drop", valid3, 1'b0);
      chk_bit("t2_busy_drop", busy3, 1'b0);
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      chk_bit("t2_done_pulse", done3, 1'b0);
      chk_bit("t2_start_in_done", valid3, 1'b0);
      chk_bit("t2_busy_after", busy3, 1'b0);

      // 3. backpressure hold on pair #3
      ready3 = 1'b0; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      chk("t3_pair0", pk3(), model(3, 1, 0));
      ready3 = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      ready3 = 1'b0;
      held = pk3();
      chk("t3_pair3", held, model(3, 1, 3));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t3_hold%0d", i), pk3(), held);
         chk_bit($sformatf("t3_hold_valid%0d", i), valid3, 1'b1);
      end
      ready3 = 1'b1;
      tick();
      chk("t3_pair4", pk3(), model(3, 1, 4));
      chk_int("t3_pair4_nbr", int'(nbr3), 7);

      // 5. reset mid-sweep at pair #100, then rst beats a simultaneous start
      for (int i = 4; i < 100; i++) tick();
      chk("t5_pair100", pk3(), model(3, 1, 100));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_bit("t5_rst_valid", valid3, 1'b0);
      chk_bit("t5_rst_busy", busy3, 1'b0);
      chk("t5_rst_pair", pk3(), 66'd0);
      rst = 1'b1; start3 = 1'b1;
      tick();
      rst = 1'b0; start3 = 1'b0;
      chk_bit("t5_rst_wins", valid3, 1'b0);
      tick();
      chk_bit("t5_still_idle", valid3, 1'b0);

      // 4. random ready with stray start pulses, restarted from (0,0)
      ready3 = 1'b0; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      chk("t5_restart_pair0", pk3(), {1'b1, 1'b0, 32'd0, 32'd0});
      for (int a = 0; a < 27; a++)
         for (int b = 0; b < 27; b++) sb[a][b] = 0;
      idx = 0; cyc = 0;
      while (!done3 && cyc < 5000) begin
         ready3 = 1'($urandom_range(0, 1));
         start3 = ($urandom_range(0, 7) == 0);
         if (valid3 && ready3) begin
            chk($sformatf("t4_pair%0d", idx), pk3(), model(3, 1, idx));
            if (ref3 < 27 && nbr3 < 27) sb[ref3][nbr3]++;
            idx++;
         end
         tick();
         cyc++;
      end
      start3 = 1'b0; ready3 = 1'b0;
      chk_bit("t4_done", done3, 1'b1);
      chk_int("t4_pair_count", idx, 378);
      homes = 0; pairs_ok = 0; bad = 0;
      for (int a = 0; a < 27; a++) begin
         if (sb[a][a] == 1) homes++;
         else bad++;
         for (int b = a + 1; b < 27; b++) begin
            if (sb[a][b] + sb[b][a] == 1) pairs_ok++;
            else bad++;
         end
      end
      chk_int("t4_home_pairs", homes, 27);
      chk_int("t4_unordered_pairs", pairs_ok, 351);
      chk_int("t4_bad_entries", bad, 0);
      tick();

      // 6. N=4 without home pairs
      ready4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk("t6_pair0", pk4(), {1'b0, 1'b0, 32'd0, 32'd61});
      idx = 0; cyc = 0; homes = 0; plast = '0;
      while (idx < 832 && cyc < 2000) begin
         if (valid4 && ready4) begin
            chk($sformatf("t6_pair%0d", idx), pk4(), model(4, 0, idx));
            if (home4) homes++;
            if (idx == 831) plast = pk4();
            idx++;
         end
         tick();
         cyc++;
      end
      chk_int("t6_pair_count", idx, 832);
      chk_int("t6_home_seen", homes, 0);
      chk("t6_pair_last", plast, {1'b0, 1'b1, 32'd63, 32'd15});
      chk_bit("t6_done", done4, 1'b1);
      chk_bit("t6_valid_drop", valid4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
